// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode values, halt FSM
// states and the per-stage control bundles.
package pipe_ctrl_pkg;

    localparam int unsigned OPC_NOP    = 0;
    localparam int unsigned OPC_ATYPE  = 1;
    localparam int unsigned OPC_BRANCH = 2;
    localparam int unsigned OPC_JUMP   = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } halt_state_e;

    // Full bundle held in ID/EX; later stages keep only what they still need.
    typedef struct packed {
        logic reg_write;
        logic branch;
        logic jump;
        logic write_op2;
        logic halt;
        logic illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic write_op2;
        logic halt;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic write_op2;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decode of opcode/function code into a control bundle.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int              OP_W    = 4,
    parameter int              FN_W    = 4,
    parameter logic [OP_W-1:0] HALT_OP = '1
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] function_code,
    output ex_ctrl_t        ctrl,
    output logic [FN_W-1:0] alu_op
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        ctrl   = '0;
        alu_op = '0;
        if (opcode == HALT_OP) begin
            ctrl.halt = 1'b1;
        end else if (opcode == OP_W'(OPC_ATYPE)) begin
            ctrl.reg_write = 1'b1;
            alu_op         = function_code;
            ctrl.write_op2 = &function_code;
        end else if (opcode == OP_W'(OPC_BRANCH)) begin
            ctrl.branch = 1'b1;
        end else if (opcode == OP_W'(OPC_JUMP)) begin
            ctrl.jump = 1'b1;
        end else if (opcode != OP_W'(OPC_NOP)) begin
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decode in ID, staged through ID/EX, EX/MEM and
// MEM/WB, with overflow kill, sticky exception and a run/drain/halt FSM.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int              OP_W    = 4,
    parameter int              FN_W    = 4,
    parameter logic [OP_W-1:0] HALT_OP = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] function_code,
    input  logic            stall,
    input  logic            flush,
    input  logic            overflow,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_write_op2,
    output logic [FN_W-1:0] ex_alu_op,
    output logic            mem_reg_write,
    output logic            mem_write_op2,
    output logic            wb_reg_write,
    output logic            wb_write_op2,
    output logic            illegal_op,
    output logic            exception,
    output logic            halted
);

    ex_ctrl_t        dec_ctrl;
    logic [FN_W-1:0] dec_alu_op;
    ex_ctrl_t        id_ex;
    logic [FN_W-1:0] id_ex_alu_op;
    mem_ctrl_t       ex_mem;
    wb_ctrl_t        mem_wb;
    halt_state_e     state;
    logic            capture;
    logic            ovf_kill;

    ctrl_decode #(
        .OP_W    (OP_W),
        .FN_W    (FN_W),
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opcode        (opcode),
        .function_code (function_code),
        .ctrl          (dec_ctrl),
        .alu_op        (dec_alu_op)
    );

    // Flush dominates stall simply because either one forces a bubble.
    assign capture  = id_valid && !stall && !flush && (state == ST_RUN);
    assign ovf_kill = overflow && id_ex.reg_write;

    // NOTE: all pipeline state is cleared by the async reset and updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex        <= '0;
            id_ex_alu_op <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
            exception    <= 1'b0;
        end else begin
            id_ex        <= capture ? dec_ctrl : '0;
            id_ex_alu_op <= capture ? dec_alu_op : '0;
            ex_mem       <= '{reg_write: id_ex.reg_write && !ovf_kill,
                              write_op2: id_ex.write_op2 && !ovf_kill,
                              halt:      id_ex.halt};
            mem_wb       <= '{reg_write: ex_mem.reg_write,
                              write_op2: ex_mem.write_op2};
            if (ovf_kill) begin
                exception <= 1'b1;
            end
        end
    end

    // The halt tag moving from EX/MEM into MEM/WB is the drain-complete point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (capture && dec_ctrl.halt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ex_mem.halt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign ex_reg_write  = id_ex.reg_write;
    assign ex_branch     = id_ex.branch;
    assign ex_jump       = id_ex.jump;
    assign ex_write_op2  = id_ex.write_op2;
    assign ex_alu_op     = id_ex_alu_op;
    assign illegal_op    = id_ex.illegal;
    assign mem_reg_write = ex_mem.reg_write;
    assign mem_write_op2 = ex_mem.write_op2;
    assign wb_reg_write  = mem_wb.reg_write;
    assign wb_write_op2  = mem_wb.write_op2;

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have parameter FN_W, default 4, function-code width; ALU op width equals FN_W.
REQ-003 SHALL have parameter HALT_OP, default all-ones (OP_W bits), halt opcode.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID-stage instruction valid
- opcode  in  OP_W  ID-stage opcode
- function_code  in  FN_W  ID-stage function code
- stall  in  1  hazard stall: bubble into EX, ID holds
- flush  in  1  taken branch/jump: kill ID instruction
- overflow  in  1  ALU overflow for the current EX instruction
- ex_reg_write, ex_branch, ex_jump, ex_write_op2  out  1 each  EX-stage controls
- ex_alu_op  out  FN_W  EX-stage ALU operation
- mem_reg_write, mem_write_op2  out  1 each  MEM-stage controls
- wb_reg_write, wb_write_op2  out  1 each  WB-stage controls
- illegal_op  out  1  one-cycle pulse: undecodable opcode entered EX
- exception  out  1  sticky overflow flag
- halted  out  1  processor halted

Function
REQ-005 Decode SHALL be combinational on ID inputs; results SHALL be registered into ID/EX, then EX/MEM, then MEM/WB (EX outputs 1 cycle after capture, WB outputs 3 cycles after).
REQ-006 Opcode 1 (A-type) SHALL decode reg_write=1, alu_op=function_code; write_op2=1 only when function_code is all-ones (swap).
REQ-007 Opcode 2 SHALL decode branch=1; opcode 3 SHALL decode jump=1; both reg_write=0, alu_op=0.
REQ-008 Opcode 0 SHALL decode to a NOP (all controls 0); HALT_OP SHALL decode to all controls 0 plus an internal halt tag carried down the pipe.
REQ-009 Any other opcode with id_valid=1 SHALL decode as NOP and SHALL pulse illegal_op for the one cycle it occupies EX.
REQ-010 id_valid=0, stall=1, flush=1 or halt state other than RUN SHALL load a bubble (all-zero controls, no tag) into ID/EX; EX/MEM and MEM/WB SHALL always advance.
REQ-011 stall and flush both 1 SHALL behave as flush.
REQ-012 overflow=1 while EX holds reg_write=1 SHALL clear reg_write and write_op2 for that instruction as it enters EX/MEM, and SHALL set exception.
REQ-013 overflow SHALL be ignored when EX holds a bubble or a non-writing instruction.
REQ-014 exception SHALL stay 1 until reset.
REQ-015 Halt FSM states RUN, DRAIN, HALTED; RUN->DRAIN when a valid, unflushed HALT_OP is captured into ID/EX; DRAIN->HALTED when the halt tag reaches MEM/WB; HALTED is terminal until reset.
REQ-016 halted SHALL be 1 only in HALTED; instructions ahead of the halt SHALL complete normally during DRAIN.
REQ-017 A halt killed by flush SHALL NOT leave RUN.

Reset
REQ-018 rst_n=0 SHALL immediately clear all pipeline registers, illegal_op, exception and halted, and force RUN, regardless of clk.
REQ-019 Reset mid-DRAIN SHALL discard the halt; first post-reset capture SHALL occur on the first rising clk with rst_n=1.

Structure
REQ-020 Opcode constants, halt-state enum and the stage control-bundle typedef SHALL live in package pipe_ctrl_pkg.
REQ-021 Combinational decode SHALL be sub-module ctrl_decode; staging, kill and FSM logic SHALL stay in the top.

Verification
REQ-022 A-type opcode 1, fn 4'b0101, id_valid=1 -> next cycle ex_reg_write=1, ex_alu_op=5; wb_reg_write=1 three cycles after capture.
REQ-023 Opcode 1, fn 4'b1111 -> ex_write_op2=1, then mem_write_op2=1, then wb_write_op2=1 on consecutive cycles.
REQ-024 Opcode 1 in EX with overflow=1 -> mem_reg_write=0 next cycle, exception=1 and held through 10 further cycles.
REQ-025 stall=1 and flush=1 together with opcode 1 -> EX bubble (all 0); opcode 7 -> illegal_op pulses exactly one cycle.
REQ-026 HALT_OP 4'b1111 captured -> halted=1 three cycles later; following opcode 1 never reaches EX; rst_n low mid-DRAIN -> halted stays 0, FSM in RUN.
